mem_stage_lsu: RTL and testbench
================================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit. It sits between the EX/MEM register and the MEM/WB register and
//  produces the mem_rd / reg_wr / mux_reg_wr / rd / ula_res / mem_res values that MEM/WB latches.
//  It runs a req/ack handshake to data memory, generates byte enables, and sign/zero-extends loads.
//  It stalls the pipeline until each memory access completes.
// PARAMETERS
//  TIMEOUT_CYCLES  255  max BUSY cycles waiting for dmem_ack before abort (1..65535)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   reset, synchronous, active-high
//  in_valid     in   1   EX/MEM holds a valid instruction
//  mem_rd_in    in   1   load
//  mem_wr_in    in   1   store (mem_rd_in&mem_wr_in never both 1)
//  reg_wr_in    in   1   writeback enable
//  mux_reg_wr_in in  1   WB mux select (1 = mem_res)
//  funct3_in    in   3   access size/sign (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  rd_in        in   5   destination register
//  ula_res_in   in   32  ALU result = effective address
//  store_in     in   32  rs2 store data, unaligned
//  flush        in   1   kill current instruction's writeback
//  dmem_req     out  1   memory request
//  dmem_we      out  1   1 = write
//  dmem_addr    out  32  word-aligned address {ula_res[31:2],2'b00}
//  dmem_be      out  4   byte enables
//  dmem_wdata   out  32  lane-shifted store data
//  dmem_rdata   in   32  read word, valid with dmem_ack
//  dmem_ack     in   1   completes request
//  stall        out  1   hold EX/MEM and earlier stages
//  mem_rd_out, reg_wr_out, mux_reg_wr_out  out 1 ; rd_out out 5 ; ula_res_out out 32 ; mem_res_out out 32
//  err_out      out  1   1-cycle pulse: timeout (or misaligned, see CONFIGURATION)
// BEHAVIOUR
//  FSM IDLE/BUSY. Reset: state=IDLE, every output 0, timeout counter 0.
//  IDLE, in_valid & no mem access: register all *_out next edge, 1-cycle latency, stall=0.
//  IDLE, in_valid & (mem_rd|mem_wr): stall=1 combinationally. Next edge: dmem_req=1 and
//   addr/we/be/wdata latched, state->BUSY, reg_wr_out=0 (bubble).
//  BUSY: stall=1; req/addr/be/wdata held stable until ack; counter increments each cycle.
//  BUSY & dmem_ack: next edge dmem_req=0, state->IDLE, *_out loaded (mem_res_out = extended load).
//   stall drops in the ack cycle. Minimum load latency: 2 cycles from accept.
//  Byte enables: byte 0001<<a[1:0]; half 0011<<{a[1],1'b0}; word 1111. wdata is replicated per lane.
//  Load extract: byte lane a[1:0], half lane a[1]. LB/LH sign-extend, LBU/LHU zero-extend.
//  Stores: mem_res_out=0, reg_wr_out=reg_wr_in (normally 0).
//  Timeout: counter==TIMEOUT_CYCLES-1 without ack -> req=0, IDLE, err_out pulse, reg_wr_out=0.
//  flush in IDLE: instruction dropped, outputs take bubble (reg_wr_out=0).
//  flush in BUSY: bus transaction still completes (no abort); the result is delivered with
//   reg_wr_out=0 and mem_rd_out=0. A flush remembered at any BUSY cycle suppresses writeback.
//  ack seen in IDLE: ignored. rst mid-BUSY: req dropped next edge; no ack expected afterwards.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: half with a[0]=1 or word with a[1:0]!=0 -> no request is issued,
//   err_out pulse next edge, reg_wr_out=0, stall=0.
//  Not defined: low address bits below access size are ignored (forced aligned). No error.
// STRUCTURE
//  Package rv32_mem_pkg: funct3 localparams F3_B=3'b000, F3_H=3'b001, F3_W=3'b010,
//   F3_BU=3'b100, F3_HU=3'b101; FSM state encodings.
//  Sub-module lsu_align (combinational): funct3 + a[1:0] + store/rdata -> be, wdata, load value.
// TESTING
//  SW 0xDEADBEEF @0x100, ack after 3 cycles -> be=1111, wdata=DEADBEEF, stall 4 cycles, reg_wr_out=0
//  LB @0x103, rdata=0x80FF_FFFF -> mem_res_out=0xFFFFFF80; LBU same -> 0x00000080
//  LH @0x102, rdata=0x8001_0000 -> be=1100, mem_res_out=0xFFFF8001; SH 0x1234 @0x102 -> wdata=12341234
//  ADD (no access) rd=5, ula=7 -> next cycle rd_out=5, ula_res_out=7, stall never high
//  TIMEOUT_CYCLES=4, no ack -> req drops after 4 BUSY cycles, err_out=1 for one cycle, FSM back to IDLE
//  LW, flush in BUSY, ack later -> reg_wr_out=0; LW @0x101 -> err only with LSU_MISALIGN_TRAP_EN

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared types for the MEM-stage load/store unit: funct3 codes, FSM states,
// captured request and MEM/WB response records.
package rv32_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } lsu_state_e;

  typedef struct packed {
    logic        mem_rd;
    logic        reg_wr;
    logic        mux_reg_wr;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [31:0] ula_res;
  } lsu_req_t;

  typedef struct packed {
    logic        mem_rd;
    logic        reg_wr;
    logic        mux_reg_wr;
    logic [4:0]  rd;
    logic [31:0] ula_res;
    logic [31:0] mem_res;
  } lsu_rsp_t;

  // Store funct3 shares the size encoding in bits [1:0] with loads.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
    case (f3[1:0])
      2'b01:   return a[0];
      2'b10:   return a != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, lane-replicated store data and
// sign/zero-extended load extraction from the selected byte/half lane.
module lsu_align
  import rv32_mem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  a_lo,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_val
);

  logic [7:0]  b_sel;
  logic [15:0] h_sel;

  always_comb begin
    b_sel    = rdata[{a_lo, 3'b000} +: 8];
    h_sel    = a_lo[1] ? rdata[31:16] : rdata[15:0];
    be       = 4'b1111;
    wdata    = store_data;
    load_val = rdata;
    case (funct3)
      F3_B, F3_BU: begin
        be       = 4'b0001 << a_lo;
        wdata    = {4{store_data[7:0]}};
        load_val = {{24{b_sel[7] & ~funct3[2]}}, b_sel};
      end
      F3_H, F3_HU: begin
        // a[0] is ignored here; misalignment is handled upstream
        be       = 4'b0011 << {a_lo[1], 1'b0};
        wdata    = {2{store_data[15:0]}};
        load_val = {{16{h_sel[15] & ~funct3[2]}}, h_sel};
      end
      default: begin
        be       = 4'b1111;
        wdata    = store_data;
        load_val = rdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage LSU: req/ack data-memory handshake with timeout, pipeline stall,
// flush-suppressed writeback. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W.
module mem_stage_lsu
  import rv32_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic        mem_rd_in,
  input  logic        mem_wr_in,
  input  logic        reg_wr_in,
  input  logic        mux_reg_wr_in,
  input  logic [2:0]  funct3_in,
  input  logic [4:0]  rd_in,
  input  logic [31:0] ula_res_in,
  input  logic [31:0] store_in,
  input  logic        flush,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        mem_rd_out,
  output logic        reg_wr_out,
  output logic        mux_reg_wr_out,
  output logic [4:0]  rd_out,
  output logic [31:0] ula_res_out,
  output logic [31:0] mem_res_out,
  output logic        err_out
);

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  lsu_state_e  state_q, state_d;
  lsu_req_t    req_q, req_d;
  lsu_rsp_t    rsp_q, rsp_d;
  logic        dreq_q, dreq_d, we_q, we_d, err_q, err_d, flushed_q, flushed_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [15:0] cnt_q, cnt_d;
  logic        access, trap, fl;
  logic [2:0]  al_f3;
  logic [1:0]  al_a;
  logic [3:0]  al_be;
  logic [31:0] al_wdata, al_load;

  assign access = mem_rd_in | mem_wr_in;
`ifdef LSU_MISALIGN_TRAP_EN
  assign trap = is_misaligned(funct3_in, ula_res_in[1:0]);
`else
  assign trap = 1'b0;
`endif

  // One aligner serves both directions: store lanes at accept, load extract in BUSY.
  assign al_f3 = (state_q == ST_BUSY) ? req_q.funct3 : funct3_in;
  assign al_a  = (state_q == ST_BUSY) ? req_q.ula_res[1:0] : ula_res_in[1:0];

  lsu_align u_align (
    .funct3     (al_f3),
    .a_lo       (al_a),
    .store_data (store_in),
    .rdata      (dmem_rdata),
    .be         (al_be),
    .wdata      (al_wdata),
    .load_val   (al_load)
  );

  always_comb begin
    state_d   = state_q;
    req_d     = req_q;
    dreq_d    = dreq_q;
    we_d      = we_q;
    addr_d    = addr_q;
    be_d      = be_q;
    wdata_d   = wdata_q;
    cnt_d     = cnt_q;
    flushed_d = flushed_q;
    rsp_d     = '0;
    err_d     = 1'b0;
    stall     = 1'b0;
    fl        = flushed_q | flush;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !flush) begin
          if (!access) begin
            rsp_d.mem_rd     = mem_rd_in;
            rsp_d.reg_wr     = reg_wr_in;
            rsp_d.mux_reg_wr = mux_reg_wr_in;
            rsp_d.rd         = rd_in;
            rsp_d.ula_res    = ula_res_in;
          end else if (trap) begin
            err_d = 1'b1;
          end else begin
            stall     = 1'b1;
            state_d   = ST_BUSY;
            dreq_d    = 1'b1;
            we_d      = mem_wr_in;
            addr_d    = {ula_res_in[31:2], 2'b00};
            be_d      = al_be;
            wdata_d   = al_wdata;
            cnt_d     = '0;
            flushed_d = 1'b0;
            req_d     = '{mem_rd: mem_rd_in, reg_wr: reg_wr_in, mux_reg_wr: mux_reg_wr_in,
                          funct3: funct3_in, rd: rd_in, ula_res: ula_res_in};
          end
        end
      end
      ST_BUSY: begin
        flushed_d = fl;
        if (dmem_ack) begin
          state_d          = ST_IDLE;
          dreq_d           = 1'b0;
          rsp_d.mem_rd     = req_q.mem_rd & ~fl;
          rsp_d.reg_wr     = req_q.reg_wr & ~fl;
          rsp_d.mux_reg_wr = req_q.mux_reg_wr;
          rsp_d.rd         = req_q.rd;
          rsp_d.ula_res    = req_q.ula_res;
          rsp_d.mem_res    = req_q.mem_rd ? al_load : '0;
        end else if (cnt_q == CNT_LAST) begin
          // Abort releases the pipeline in this cycle; the result is a bubble.
          state_d = ST_IDLE;
          dreq_d  = 1'b0;
          err_d   = 1'b1;
        end else begin
          stall = 1'b1;
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      rsp_q     <= '0;
      dreq_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      be_q      <= '0;
      wdata_q   <= '0;
      cnt_q     <= '0;
      flushed_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      rsp_q     <= rsp_d;
      dreq_q    <= dreq_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      be_q      <= be_d;
      wdata_q   <= wdata_d;
      cnt_q     <= cnt_d;
      flushed_q <= flushed_d;
      err_q     <= err_d;
    end
  end

  assign dmem_req       = dreq_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign mem_rd_out     = rsp_q.mem_rd;
  assign reg_wr_out     = rsp_q.reg_wr;
  assign mux_reg_wr_out = rsp_q.mux_reg_wr;
  assign rd_out         = rsp_q.rd;
  assign ula_res_out    = rsp_q.ula_res;
  assign mem_res_out    = rsp_q.mem_res;
  assign err_out        = err_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: table of single memory accesses plus
// hand sequences for pass-through, flush, reset, stray ack and misalignment.
module tb_mem_stage_lsu;
  import rv32_mem_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 0, mem_rd_in = 0, mem_wr_in = 0, reg_wr_in = 0, mux_reg_wr_in = 0, flush = 0;
  logic [2:0]  funct3_in = '0;
  logic [4:0]  rd_in = '0;
  logic [31:0] ula_res_in = '0, store_in = '0, dmem_rdata = '0;
  logic        dmem_ack = 0;
  logic        dmem_req, dmem_we, stall, mem_rd_out, reg_wr_out, mux_reg_wr_out, err_out;
  logic [31:0] dmem_addr, dmem_wdata, ula_res_out, mem_res_out;
  logic [3:0]  dmem_be;
  logic [4:0]  rd_out;

  always #5 clk = ~clk;

  mem_stage_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_rd_in(mem_rd_in), .mem_wr_in(mem_wr_in),
    .reg_wr_in(reg_wr_in), .mux_reg_wr_in(mux_reg_wr_in), .funct3_in(funct3_in), .rd_in(rd_in),
    .ula_res_in(ula_res_in), .store_in(store_in), .flush(flush), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .stall(stall), .mem_rd_out(mem_rd_out),
    .reg_wr_out(reg_wr_out), .mux_reg_wr_out(mux_reg_wr_out), .rd_out(rd_out),
    .ula_res_out(ula_res_out), .mem_res_out(mem_res_out), .err_out(err_out)
  );

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rd_op, wr_op;
    logic [2:0]  f3;
    logic [31:0] addr, store, rdata;
    int          ack_at;      // BUSY cycle carrying ack, 0 = never
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_res;
    logic        e_reg_wr, e_err;
    int          e_stalls, e_busy;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                              input logic [31:0] addr, input logic [31:0] store,
                              input logic [31:0] rdata, input int ack_at, input logic [3:0] e_be,
                              input logic [31:0] e_wdata, input logic [31:0] e_res,
                              input logic e_reg_wr, input logic e_err, input int e_stalls,
                              input int e_busy);
    vec_t v;
    v.rd_op = rd_op; v.wr_op = wr_op; v.f3 = f3; v.addr = addr; v.store = store;
    v.rdata = rdata; v.ack_at = ack_at; v.e_be = e_be; v.e_wdata = e_wdata; v.e_res = e_res;
    v.e_reg_wr = e_reg_wr; v.e_err = e_err; v.e_stalls = e_stalls; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic drive_op(input logic rd_op, input logic wr_op, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] store, input logic [4:0] rd);
    in_valid = 1; mem_rd_in = rd_op; mem_wr_in = wr_op; reg_wr_in = rd_op; mux_reg_wr_in = rd_op;
    funct3_in = f3; ula_res_in = addr; store_in = store; rd_in = rd;
  endtask

  task automatic idle_inputs();
    in_valid = 0; mem_rd_in = 0; mem_wr_in = 0; reg_wr_in = 0; mux_reg_wr_in = 0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int stalls = 0, busy = 0;
    logic [4:0] rdv = 5'(idx + 1);
    @(negedge clk);
    drive_op(v.rd_op, v.wr_op, v.f3, v.addr, v.store, rdv);
    #1 if (stall) stalls++;
    @(posedge clk); #1;
    chk($sformatf("v%0d_req", idx), 32'(dmem_req), 32'd1);
    chk($sformatf("v%0d_addr", idx), dmem_addr, {v.addr[31:2], 2'b00});
    chk($sformatf("v%0d_be", idx), 32'(dmem_be), 32'(v.e_be));
    chk($sformatf("v%0d_wdata", idx), dmem_wdata, v.e_wdata);
    chk($sformatf("v%0d_we", idx), 32'(dmem_we), 32'(v.wr_op));
    chk($sformatf("v%0d_bubble", idx), 32'(reg_wr_out), 32'd0);
    while (busy < 20) begin
      busy++;
      if (busy == v.ack_at) begin dmem_ack = 1; dmem_rdata = v.rdata; end
      #1 if (stall) stalls++;
      @(posedge clk); #1;
      dmem_ack = 0;
      if (!dmem_req) break;
    end
    idle_inputs();
    chk($sformatf("v%0d_busy_cycles", idx), 32'(busy), 32'(v.e_busy));
    chk($sformatf("v%0d_stall_cycles", idx), 32'(stalls), 32'(v.e_stalls));
    chk($sformatf("v%0d_mem_res", idx), mem_res_out, v.e_res);
    chk($sformatf("v%0d_reg_wr", idx), 32'(reg_wr_out), 32'(v.e_reg_wr));
    chk($sformatf("v%0d_err", idx), 32'(err_out), 32'(v.e_err));
    if (!v.e_err) chk($sformatf("v%0d_rd", idx), 32'(rd_out), 32'(rdv));
    @(posedge clk); #1;
    chk($sformatf("v%0d_err_after", idx), 32'(err_out), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //             rd wr f3     addr          store         rdata         ack be       wdata         res           rw err st bz
    vecs[0] = mk(0, 1, F3_W,  32'h0000_0100, 32'hDEAD_BEEF, 32'h0,        4, 4'b1111, 32'hDEAD_BEEF, 32'h0,        0, 0, 4, 4);
    vecs[1] = mk(1, 0, F3_B,  32'h0000_0103, 32'h0,         32'h80FF_FFFF, 1, 4'b1000, 32'h0,        32'hFFFF_FF80, 1, 0, 1, 1);
    vecs[2] = mk(1, 0, F3_BU, 32'h0000_0103, 32'h0,         32'h80FF_FFFF, 2, 4'b1000, 32'h0,        32'h0000_0080, 1, 0, 2, 2);
    vecs[3] = mk(1, 0, F3_H,  32'h0000_0102, 32'h0,         32'h8001_0000, 2, 4'b1100, 32'h0,        32'hFFFF_8001, 1, 0, 2, 2);
    vecs[4] = mk(1, 0, F3_HU, 32'h0000_0100, 32'h0,         32'h8001_7FFF, 3, 4'b0011, 32'h0,        32'h0000_7FFF, 1, 0, 3, 3);
    vecs[5] = mk(0, 1, F3_H,  32'h0000_0102, 32'h0000_1234, 32'h0,        1, 4'b1100, 32'h1234_1234, 32'h0,        0, 0, 1, 1);
    vecs[6] = mk(0, 1, F3_B,  32'h0000_0101, 32'h0000_00A5, 32'h0,        1, 4'b0010, 32'hA5A5_A5A5, 32'h0,        0, 0, 1, 1);
    vecs[7] = mk(1, 0, F3_W,  32'h0000_0200, 32'h0,         32'h1234_5678, 4, 4'b1111, 32'h0,        32'h1234_5678, 1, 0, 4, 4);
    vecs[8] = mk(1, 0, F3_W,  32'h0000_0300, 32'h0,         32'h0,        0, 4'b1111, 32'h0,        32'h0,        0, 1, 4, 4);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(dmem_req), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_reg_wr", 32'(reg_wr_out), 32'd0);
    chk("rst_err", 32'(err_out), 32'd0);
    chk("rst_mem_res", mem_res_out, 32'd0);
    chk("rst_ula", ula_res_out, 32'd0);
    rst = 0;

    // Non-memory instruction passes through with one cycle latency, no stall
    @(negedge clk);
    in_valid = 1; reg_wr_in = 1; rd_in = 5'd5; ula_res_in = 32'd7; funct3_in = 3'b000;
    #1 chk("add_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    chk("add_rd", 32'(rd_out), 32'd5);
    chk("add_ula", ula_res_out, 32'd7);
    chk("add_reg_wr", 32'(reg_wr_out), 32'd1);
    chk("add_req", 32'(dmem_req), 32'd0);
    @(posedge clk); #1;
    chk("add_then_bubble", 32'(reg_wr_out), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i], i);

    // Flush during BUSY: transaction completes, writeback suppressed
    @(negedge clk);
    drive_op(1, 0, F3_W, 32'h0000_0400, 32'h0, 5'd9);
    @(posedge clk); #1 flush = 1;
    @(posedge clk); #1 flush = 0;
    chk("flush_busy_req_held", 32'(dmem_req), 32'd1);
    @(posedge clk); #1 dmem_ack = 1; dmem_rdata = 32'h55AA_55AA;
    @(posedge clk); #1 dmem_ack = 0;
    idle_inputs();
    chk("flush_busy_req_done", 32'(dmem_req), 32'd0);
    chk("flush_busy_reg_wr", 32'(reg_wr_out), 32'd0);
    chk("flush_busy_mem_rd", 32'(mem_rd_out), 32'd0);
    chk("flush_busy_mem_res", mem_res_out, 32'h55AA_55AA);
    chk("flush_busy_rd", 32'(rd_out), 32'd9);

    // Flush in IDLE drops the access
    @(negedge clk);
    drive_op(1, 0, F3_W, 32'h0000_0500, 32'h0, 5'd10);
    flush = 1;
    #1 chk("flush_idle_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    flush = 0; idle_inputs();
    chk("flush_idle_req", 32'(dmem_req), 32'd0);
    chk("flush_idle_reg_wr", 32'(reg_wr_out), 32'd0);

    // Stray ack while IDLE is ignored
    @(negedge clk);
    dmem_ack = 1; dmem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1 dmem_ack = 0;
    chk("stray_ack_reg_wr", 32'(reg_wr_out), 32'd0);
    chk("stray_ack_mem_res", mem_res_out, 32'd0);
    chk("stray_ack_req", 32'(dmem_req), 32'd0);

    // Reset in the middle of BUSY drops the request
    @(negedge clk);
    drive_op(1, 0, F3_W, 32'h0000_0600, 32'h0, 5'd11);
    @(posedge clk); #1;
    chk("rst_busy_req_up", 32'(dmem_req), 32'd1);
    rst = 1; idle_inputs();
    @(posedge clk); #1 rst = 0;
    chk("rst_busy_req_down", 32'(dmem_req), 32'd0);
    chk("rst_busy_reg_wr", 32'(reg_wr_out), 32'd0);

    // Misaligned word load
    @(negedge clk);
    drive_op(1, 0, F3_W, 32'h0000_0101, 32'h0, 5'd12);
`ifdef LSU_MISALIGN_TRAP_EN
    #1 chk("mis_stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    idle_inputs();
    chk("mis_err", 32'(err_out), 32'd1);
    chk("mis_req", 32'(dmem_req), 32'd0);
    chk("mis_reg_wr", 32'(reg_wr_out), 32'd0);
    @(posedge clk); #1;
    chk("mis_err_after", 32'(err_out), 32'd0);
`else
    @(posedge clk); #1;
    chk("mis_req", 32'(dmem_req), 32'd1);
    chk("mis_addr", dmem_addr, 32'h0000_0100);
    chk("mis_be", 32'(dmem_be), 32'hF);
    dmem_ack = 1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1 dmem_ack = 0;
    idle_inputs();
    chk("mis_err", 32'(err_out), 32'd0);
    chk("mis_mem_res", mem_res_out, 32'hCAFE_F00D);
    chk("mis_reg_wr", 32'(reg_wr_out), 32'd1);
`endif

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
